coord_list_builder: RTL and testbench

//  Parametrised successor to the single-point coordinate entry FSM. Collects a list of (x,y)

---
 rtl/coord_list_builder.sv | 150 +++++++++++++++
 tb/tb_coord_list_builder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/coord_list_builder.sv
// coord_list_builder
//   Collects a list of (x,y) coordinate pairs from switches and a write button.
//   Each pair is written as one packed word {y,x} to consecutive addresses of a
//   coordinate RAM. The block tracks how many pairs have been entered and whether
//   the list is full. It raises done once the operator ends initialisation.
//
//   Optional feature: define COORD_HEX_EN to drive the hex0..hex5 display nibbles
//   from x_reg, y_reg and count. When COORD_HEX_EN is not defined they are tied to 0.
//
// Parameters
//   COORD_W  width of each coordinate
//   DEPTH    maximum number of pairs (>= 2); ADDR_W = $clog2(DEPTH)
// Ports
//   clk, reset              clock; synchronous active-high reset
//   x_in, y_in              coordinate switches
//   write_en                capture button (level; rising edge acted on)
//   enterNewCoord           in OPTION: start another pair
//   finishInit              in OPTION: end entry
//   mem_addr/data/wren      RAM write port
//   count, full, done       entry count, list-full flag, entry-finished flag
//   hex0..hex5              display nibbles
module coord_list_builder #(
  parameter int COORD_W = 8,
  parameter int DEPTH   = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [COORD_W-1:0]            x_in,
  input  logic [COORD_W-1:0]            y_in,
  input  logic                          write_en,
  input  logic                          enterNewCoord,
  input  logic                          finishInit,
  output logic [$clog2(DEPTH)-1:0]      mem_addr,
  output logic [2*COORD_W-1:0]          mem_data,
  output logic                          mem_wren,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          done,
  output logic [3:0]                    hex0,
  output logic [3:0]                    hex1,
  output logic [3:0]                    hex2,
  output logic [3:0]                    hex3,
  output logic [3:0]                    hex4,
  output logic [3:0]                    hex5
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_GET_X  = 3'd1;
  localparam logic [2:0] S_GET_Y  = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_OPTION = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]         state, state_nxt;
  logic [ADDR_W:0]    count_nxt;
  logic [COORD_W-1:0] x_reg, y_reg;
  logic               write_en_q;
  logic               wr_rise;

  // One capture per press, however long the button is held.
  assign wr_rise = write_en & ~write_en_q;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      S_INIT:   state_nxt = S_GET_X;
      S_GET_X:  if (wr_rise) state_nxt = S_GET_Y;
      S_GET_Y:  if (wr_rise) state_nxt = S_WRITE;
      S_WRITE: begin
        state_nxt = S_OPTION;
        if (count != DEPTH_C) count_nxt = count + 1'b1;
      end
      S_OPTION: begin
        if (enterNewCoord && !full) state_nxt = S_GET_X;
        else if (finishInit)        state_nxt = S_FINISH;
      end
      S_FINISH: state_nxt = S_FINISH;
      default:  state_nxt = S_INIT;
    endcase
  end

  // The status outputs are flops that load the decoded next value. This keeps
  // them glitch-free and aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT;
      count      <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      write_en_q <= 1'b0;
      mem_wren   <= 1'b0;
      done       <= 1'b0;
      full       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      write_en_q <= write_en;
      if (state == S_GET_X && wr_rise) x_reg <= x_in;
      if (state == S_GET_Y && wr_rise) y_reg <= y_in;
      mem_wren   <= (state_nxt == S_WRITE);
      done       <= (state_nxt == S_FINISH);
      full       <= (count_nxt == DEPTH_C);
    end
  end

  // count stays below DEPTH whenever a write happens, so the address never wraps.
  assign mem_addr = count[ADDR_W-1:0];
  assign mem_data = {y_reg, x_reg};

`ifdef COORD_HEX_EN
  logic [7:0] x8, y8, c8;

  // Take the low byte of each source. Bits above the source width read as 0.
  always_comb begin
    x8 = '0;
    y8 = '0;
    c8 = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < COORD_W) begin
        x8[i] = x_reg[i];
        y8[i] = y_reg[i];
      end
      if (i <= ADDR_W) c8[i] = count[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {hex1, hex0} <= '0;
      {hex3, hex2} <= '0;
      {hex5, hex4} <= '0;
    end else begin
      {hex1, hex0} <= x8;
      {hex3, hex2} <= y8;
      {hex5, hex4} <= c8;
    end
  end
`else
  assign hex0 = 4'h0;
  assign hex1 = 4'h0;
  assign hex2 = 4'h0;
  assign hex3 = 4'h0;
  assign hex4 = 4'h0;
  assign hex5 = 4'h0;
`endif

endmodule

// File: tb/tb_coord_list_builder.sv
// Directed bench for coord_list_builder.
// Two instances share one stimulus stream: the default DEPTH=256 and DEPTH=4.
// The DEPTH=4 instance exercises the full condition.
module tb_coord_list_builder;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] x_in, y_in;
  logic       write_en, enterNewCoord, finishInit;

  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic [8:0]  count;
  logic        full, done;
  logic [3:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  logic [1:0]  mem_addr4;
  logic [15:0] mem_data4;
  logic        mem_wren4;
  logic [2:0]  count4;
  logic        full4, done4;
  logic [3:0]  h40, h41, h42, h43, h44, h45;

  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int wr_cnt4 = 0;

  always #5 clk = ~clk;

  coord_list_builder dut (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .write_en(write_en),
    .enterNewCoord(enterNewCoord), .finishInit(finishInit),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .count(count), .full(full), .done(done),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  coord_list_builder #(.COORD_W(8), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .write_en(write_en),
    .enterNewCoord(enterNewCoord), .finishInit(finishInit),
    .mem_addr(mem_addr4), .mem_data(mem_data4), .mem_wren(mem_wren4),
    .count(count4), .full(full4), .done(done4),
    .hex0(h40), .hex1(h41), .hex2(h42), .hex3(h43), .hex4(h44), .hex5(h45)
  );

  // Count write strobes, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_wren)  wr_cnt++;
    if (mem_wren4) wr_cnt4++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then step out of INIT into GET_X.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Enter one pair from GET_X. Stops in WRITE and checks the RAM port there,
  // then moves on to OPTION.
  task automatic pair(input string tag, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] exp_addr);
    x_in = x; write_en = 1'b1; tick();
    write_en = 1'b0; tick();
    y_in = y; write_en = 1'b1; tick();
    write_en = 1'b0;
    check({tag, " wren"}, 32'(mem_wren), 32'd1);
    check({tag, " addr"}, 32'(mem_addr), 32'(exp_addr));
    check({tag, " data"}, 32'(mem_data), {16'h0, y, x});
    tick();
    check({tag, " wren off"}, 32'(mem_wren), 32'd0);
  endtask

  task automatic pulse_new();
    enterNewCoord = 1'b1; tick(); enterNewCoord = 1'b0;
  endtask

  task automatic pulse_finish();
    finishInit = 1'b1; tick(); finishInit = 1'b0;
  endtask

  initial begin
    int w0;
    reset = 1'b1; x_in = '0; y_in = '0;
    write_en = 1'b0; enterNewCoord = 1'b0; finishInit = 1'b0;

    // Reset state
    tick(); tick();
    check("rst count", 32'(count), 0);
    check("rst wren", 32'(mem_wren), 0);
    check("rst done", 32'(done), 0);
    check("rst full", 32'(full), 0);
`ifdef COORD_HEX_EN
    check("rst hex", {8'h0, hex5, hex4, hex3, hex2, hex1, hex0}, 0);
`endif

    // 1: single pair, then finish
    do_reset();
    w0 = wr_cnt;
    pair("t1", 8'h12, 8'h34, 8'd0);
    check("t1 count", 32'(count), 1);
    check("t1 done before", 32'(done), 0);
    pulse_finish();
    check("t1 done", 32'(done), 1);
    check("t1 count kept", 32'(count), 1);
    check("t1 pulses", 32'(wr_cnt - w0), 1);
`ifdef COORD_HEX_EN
    check("t1 hex", {8'h0, hex5, hex4, hex3, hex2, hex1, hex0}, 32'h013412);
`endif
    tick(); tick();
    check("t1 done held", 32'(done), 1);

    // 2: three pairs
    do_reset();
    w0 = wr_cnt;
    pair("t2a", 8'h01, 8'h02, 8'd0); pulse_new();
    pair("t2b", 8'h03, 8'h04, 8'd1); pulse_new();
    pair("t2c", 8'h05, 8'h06, 8'd2);
    check("t2 count", 32'(count), 3);
    check("t2 pulses", 32'(wr_cnt - w0), 3);

    // 3: write_en held for 10 cycles in GET_X gives exactly one capture
    do_reset();
    w0 = wr_cnt;
    x_in = 8'hAA; write_en = 1'b1; tick();
    x_in = 8'hBB;
    repeat (9) tick();
    check("t3 no wren", 32'(wr_cnt - w0), 0);
    check("t3 count", 32'(count), 0);
    write_en = 1'b0; tick();
    y_in = 8'hCC; write_en = 1'b1; tick();
    write_en = 1'b0;
    check("t3 wren", 32'(mem_wren), 1);
    check("t3 data", 32'(mem_data), 32'h0000CCAA);
    tick();

    // 5: enterNewCoord and finishInit together while not full, so the new pair wins
    enterNewCoord = 1'b1; finishInit = 1'b1; tick();
    enterNewCoord = 1'b0; finishInit = 1'b0;
    tick();
    check("t5 done", 32'(done), 0);
    pair("t5 next", 8'h07, 8'h08, 8'd1);
    check("t5 count", 32'(count), 2);

    // 4: DEPTH=4 fills up; enterNewCoord ignored once full
    do_reset();
    w0 = wr_cnt4;
    pair("t4a", 8'h10, 8'h20, 8'd0); pulse_new();
    pair("t4b", 8'h11, 8'h21, 8'd1); pulse_new();
    pair("t4c", 8'h12, 8'h22, 8'd2);
    check("t4 full early", 32'(full4), 0);
    pulse_new();
    pair("t4d", 8'h13, 8'h23, 8'd3);
    check("t4 full", 32'(full4), 1);
    check("t4 count4", 32'(count4), 4);
    check("t4 big not full", 32'(full), 0);
    pulse_new();
    // dut follows this pair; dut4 must stay in OPTION and not write.
    x_in = 8'h55; write_en = 1'b1; tick(); write_en = 1'b0; tick();
    y_in = 8'h66; write_en = 1'b1; tick(); write_en = 1'b0; tick();
    check("t4 no 5th write", 32'(wr_cnt4 - w0), 4);
    check("t4 count4 held", 32'(count4), 4);
    check("t4 done4 before", 32'(done4), 0);
    pulse_finish();
    check("t4 done4", 32'(done4), 1);
    check("t4 full held", 32'(full4), 1);

    // 6: reset during WRITE abandons the write
    do_reset();
    x_in = 8'h9A; write_en = 1'b1; tick(); write_en = 1'b0; tick();
    y_in = 8'hBC; write_en = 1'b1; tick(); write_en = 1'b0;
    check("t6 in write", 32'(mem_wren), 1);
    reset = 1'b1; tick();
    check("t6 wren", 32'(mem_wren), 0);
    check("t6 count", 32'(count), 0);
    check("t6 done", 32'(done), 0);
`ifdef COORD_HEX_EN
    check("t6 hex", {8'h0, hex5, hex4, hex3, hex2, hex1, hex0}, 0);
`endif
    reset = 1'b0; tick(); tick();
    check("t6 idle wren", 32'(mem_wren), 0);
    check("t6 idle count", 32'(count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
